// File: rtl/mram_cache.sv
// mram_cache: direct-mapped, write-through, one-word-per-line cache placed
// between a Wishbone classic master (CPU) and the mram SPI slave.
//
// Read hits are acknowledged one cycle after the strobe is sampled. Read
// misses fetch the word from mram and fill the line. Writes always go to
// mram and update the line only if it already hits (no write-allocate).
//
// Parameters:
//   ADDRESSBITS  byte-address bits decoded by mram; higher adr_i bits alias
//   INDEXBITS    log2(number of lines)
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   stb_i, we_i, sel_i    upstream Wishbone request
//   dat_i, adr_i          upstream write data, word address
//   dat_o, ack_o          upstream read data, one-cycle acknowledge
//   inv_i                 pulse: invalidate every line
//   mem_stb_o ... mem_adr_o  downstream request to mram
//   mem_dat_i, mem_ack_i  downstream response from mram
//   hit_cnt_o, miss_cnt_o saturating statistics (MRAM_CACHE_STATS_EN only)
//
// Optional feature macro: MRAM_CACHE_STATS_EN adds the statistics counters.

module mram_cache #(
    parameter int ADDRESSBITS = 16,
    parameter int INDEXBITS   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [29:0] adr_i,
    output logic        ack_o,
    input  logic        inv_i,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_dat_o,
    output logic [29:0] mem_adr_o,
    input  logic [31:0] mem_dat_i,
    input  logic        mem_ack_i
`ifdef MRAM_CACHE_STATS_EN
    ,
    output logic [15:0] hit_cnt_o,
    output logic [15:0] miss_cnt_o
`endif
);

    localparam int LINES   = 1 << INDEXBITS;
    localparam int TAGBITS = ADDRESSBITS - 2 - INDEXBITS;

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        WRITE,
        ACK
    } state_t;

    state_t state_q;

    logic [LINES-1:0]   valid_q;
    logic [TAGBITS-1:0] tag_q  [LINES];
    logic [31:0]        word_q [LINES];

    logic        ack_q;
    logic [31:0] dat_q;
    logic        mem_stb_q;
    logic        mem_we_q;
    logic [3:0]  mem_sel_q;
    logic [31:0] mem_dat_q;
    logic [29:0] mem_adr_q;

    // Upstream lookup, combinational from adr_i
    logic [INDEXBITS-1:0] req_idx;
    logic [TAGBITS-1:0]   req_tag;
    logic                 req_hit;

    // Lookup for the request already latched toward mram
    logic [INDEXBITS-1:0] mem_idx;
    logic [TAGBITS-1:0]   mem_tag;
    logic                 mem_hit;

    logic        fill_en;
    logic        merge_en;
    logic [31:0] word_d;

    // Bits above the mram decode range alias and are deliberately ignored
    logic unused_adr;
    assign unused_adr = ^adr_i[29:ADDRESSBITS-2];

    assign req_idx = adr_i[INDEXBITS-1:0];
    assign req_tag = adr_i[ADDRESSBITS-3:INDEXBITS];
    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign mem_idx = mem_adr_q[INDEXBITS-1:0];
    assign mem_tag = mem_adr_q[ADDRESSBITS-3:INDEXBITS];
    assign mem_hit = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);

    // An invalidate landing on the completing edge suppresses the update
    assign fill_en  = (state_q == MISS) && mem_ack_i && !inv_i;
    assign merge_en = (state_q == WRITE) && mem_ack_i && mem_hit && !inv_i;

    always_comb begin
        word_d = word_q[mem_idx];
        if (state_q == MISS) begin
            word_d = mem_dat_i;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (mem_sel_q[b]) begin
                    word_d[8*b +: 8] = mem_dat_q[8*b +: 8];
                end
            end
        end
    end

    // Line storage needs no reset; the valid bits qualify it
    always_ff @(posedge clk_i) begin
        if (fill_en || merge_en) begin
            word_q[mem_idx] <= word_d;
        end
        if (fill_en) begin
            tag_q[mem_idx] <= mem_tag;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            mem_stb_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_sel_q <= '0;
            mem_dat_q <= '0;
            mem_adr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stb_i) begin
                        if (we_i || !req_hit) begin
                            mem_adr_q <= adr_i;
                            mem_sel_q <= sel_i;
                            mem_dat_q <= dat_i;
                            mem_we_q  <= we_i;
                            mem_stb_q <= 1'b1;
                            state_q   <= we_i ? WRITE : MISS;
                        end else begin
                            dat_q   <= word_q[req_idx];
                            ack_q   <= 1'b1;
                            state_q <= ACK;
                        end
                    end
                end
                MISS: begin
                    if (mem_ack_i) begin
                        mem_stb_q        <= 1'b0;
                        dat_q            <= mem_dat_i;
                        valid_q[mem_idx] <= 1'b1;
                        ack_q            <= 1'b1;
                        state_q          <= ACK;
                    end
                end
                WRITE: begin
                    if (mem_ack_i) begin
                        mem_stb_q <= 1'b0;
                        ack_q     <= 1'b1;
                        state_q   <= ACK;
                    end
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
            // Later assignment wins, so this also cancels a same-edge fill
            if (inv_i) begin
                valid_q <= '0;
            end
        end
    end

    assign ack_o     = ack_q;
    assign dat_o     = dat_q;
    assign mem_stb_o = mem_stb_q;
    assign mem_we_o  = mem_we_q;
    assign mem_sel_o = mem_sel_q;
    assign mem_dat_o = mem_dat_q;
    assign mem_adr_o = mem_adr_q;

`ifdef MRAM_CACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == IDLE && stb_i && !we_i) begin
            if (req_hit) begin
                if (hit_cnt_q != 16'hFFFF) begin
                    hit_cnt_q <= hit_cnt_q + 16'd1;
                end
            end else begin
                if (miss_cnt_q != 16'hFFFF) begin
                    miss_cnt_q <= miss_cnt_q + 16'd1;
                end
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
